// File: rtl/operand_reducer.sv
// Streaming reducer: folds NUM_OPS unsigned operands into one sum/max/min/average result.
// Optional macro OPERAND_REDUCER_SAT_EN clamps an overflowing sum instead of wrapping it.
module operand_reducer #(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             result,
    output logic [$clog2(NUM_OPS):0]   count
);
    localparam int LOGN  = $clog2(NUM_OPS);
    localparam int CNT_W = LOGN + 1;
    localparam int ACC_W = WIDTH + LOGN;
    localparam int RES_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_MIN = 2'b10;
    localparam logic [1:0] MODE_AVG = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;
    logic [ACC_W-1:0]   operand;

    // Maps the final accumulator to the presented result for the latched op.
    function automatic logic [RES_W-1:0] finalize(input logic [1:0] m, input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] shifted;
        logic [RES_W-1:0] r;
        shifted = a >> LOGN;
        case (m)
            MODE_AVG: r = shifted[RES_W-1:0];
            MODE_MAX,
            MODE_MIN: r = a[RES_W-1:0];
            default: begin
`ifdef OPERAND_REDUCER_SAT_EN
                if (a > ACC_W'({RES_W{1'b1}})) r = {RES_W{1'b1}};
                else                           r = a[RES_W-1:0];
`else
                r = a[RES_W-1:0];
`endif
            end
        endcase
        return r;
    endfunction

    assign accept  = in_valid && in_ready_q && (state_q != DONE);
    assign operand = ACC_W'(in_data);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = mode;
                    acc_d   = operand;
                    count_d = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    case (mode_q)
                        MODE_MAX: acc_d = (operand > acc_q) ? operand : acc_q;
                        MODE_MIN: acc_d = (operand < acc_q) ? operand : acc_q;
                        default:  acc_d = acc_q + operand;
                    endcase
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = finalize(mode_q, acc_d);
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    count_d     = '0;
                    result_d    = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready is registered, so it drops on the same edge that enters DONE.
        in_ready_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_SUM;
            acc_q       <= '0;
            count_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign count     = count_q;
endmodule
